// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage feeding decode.
//
// Owns the program counter, issues one word read per cycle to a fixed
// one-cycle-latency instruction memory, and buffers the returned words in a
// small FIFO. Decode drains the FIFO through a valid/ready handshake. A taken
// branch or jump from execute flushes the FIFO and restarts fetch at the
// target.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   imem_req         read request this cycle
//   imem_addr        word address of the request (current PC)
//   imem_rdata       read data, valid the cycle after imem_req
//   redirect_valid   execute resolved a taken branch/jump this cycle
//   redirect_target  new PC to fetch from
//   out_valid        head entry valid to decode
//   out_ready        decode accepts the head this cycle
//   out_instr        head instruction
//   out_pc           PC of the head instruction
//   out_pc_plus4     out_pc + 4 (wraps at 2^ADDR_W)
module instr_fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Stage p0: PC of the next request.
  logic [ADDR_W-1:0] pc_p0;

  // Stage p1: request in flight to memory and the PC it was issued with.
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;

  // Queue storage and control.
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic [CNT_W:0]    occ;

  assign out_valid    = (count != '0);
  assign out_instr    = instr_q[head];
  assign out_pc       = pc_q[head];
  assign out_pc_plus4 = pc_q[head] + ADDR_W'(4);

  assign pop  = out_valid & out_ready;
  // A response is dropped when it lands in a flush or reset cycle.
  assign push = vld_p1 & ~redirect_valid & ~rst;

  // Occupancy after this cycle if no new request were issued. Counting the
  // in-flight slot reserves room for its response, so a full queue can never
  // be pushed.
  assign occ = (CNT_W+1)'(count) + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);

  assign imem_req  = ~rst & ~redirect_valid & (occ < (CNT_W+1)'(DEPTH));
  assign imem_addr = pc_p0;

  // Control state: PC, in-flight flag, pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // Flush wins over push and issue; a coincident pop has already been
      // taken by decode this cycle.
      pc_p0  <= redirect_target;
      vld_p1 <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      vld_p1 <= imem_req;
      if (imem_req) begin
        pc_p0 <= pc_p0 + ADDR_W'(4);
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stage p1 -> queue: datapath registers carry no reset.
  always_ff @(posedge clk) begin
    if (imem_req) begin
      pc_p1 <= pc_p0;
    end
    if (push) begin
      instr_q[tail] <= imem_rdata;
      pc_q[tail]    <= pc_p1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_w = 1'b1;

  // Main instance (RESET_PC = 0)
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus4;

  // Wrap instance (RESET_PC = FFFF_FFF8)
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rdata;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [DW-1:0] w_instr;
  logic [AW-1:0] w_pc;
  logic [AW-1:0] w_pc_plus4;

  int vectors = 0;
  int miscompares = 0;
  int occ = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_w[$];

  always #5 clk = ~clk;

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .out_valid(w_valid), .out_ready(w_ready), .out_instr(w_instr),
    .out_pc(w_pc), .out_pc_plus4(w_pc_plus4)
  );

  // One-cycle instruction memories returning addr ^ SALT.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ SALT) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? (w_addr ^ SALT) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops expected PCs whenever a handshake completes.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (rst) begin
      chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    end else begin
      chk("occupancy_le_depth", {31'b0, (occ <= DEPTH)}, 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_instr", out_instr, e ^ SALT);
          chk("out_pc_plus4", out_pc_plus4, e + 32'd4);
        end
      end
    end
    if (!rst_w && w_valid && w_ready) begin
      if (exp_w.size() == 0) begin
        chk("wrap_unexpected_pc", w_pc, 32'h1234_5678);
      end else begin
        e = exp_w.pop_front();
        chk("wrap_out_pc", w_pc, e);
        chk("wrap_out_instr", w_instr, e ^ SALT);
        chk("wrap_out_pc_plus4", w_pc_plus4, e + 32'd4);
      end
    end
    // Issued-but-not-delivered count; flushed by reset or redirect.
    if (rst || redirect_valid) occ = 0;
    else occ = occ + int'(imem_req) - int'(out_valid && out_ready);
  end

  initial begin
    // Reset, with a redirect presented during reset that must be ignored.
    cyc();
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h500;
    cyc(); redirect_valid = 1'b0;
    #3;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_imem_req", {31'b0, imem_req}, 32'd0);

    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    exp_w.push_back(32'hFFFF_FFF8);
    exp_w.push_back(32'hFFFF_FFFC);
    exp_w.push_back(32'h0000_0000);

    // Phase 1: streaming with out_ready high.
    cyc(); rst = 1'b0; rst_w = 1'b0; out_ready = 1'b1; w_ready = 1'b1;   // C1
    #3;
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", {31'b0, out_valid}, 32'd0);
    cyc(); #3; chk("c2_valid", {31'b0, out_valid}, 32'd0);                 // C2
    cyc(); #3;                                                             // C3
    chk("c3_valid", {31'b0, out_valid}, 32'd1);
    chk("c3_pc", out_pc, 32'h0);
    chk("c3_pc_plus4", out_pc_plus4, 32'h4);
    cyc(); #3; chk("wrap_plus4_at_fffc", w_pc_plus4, 32'h0);               // C4
    cyc();                                                                 // C5
    cyc(); w_ready = 1'b0;                                                 // C6
    cyc(); rst_w = 1'b1;                                                   // C7
    repeat (3) cyc();                                                      // C8..C10
    cyc(); out_ready = 1'b0; rst = 1'b1;                                   // C11

    // Phase 2: backpressure, then redirects and a mid-stream reset.
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);   exp_q.push_back(32'hC);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    exp_q.push_back(32'h20);  exp_q.push_back(32'h40);
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);

    cyc(); rst = 1'b0; #3;                                                 // C1
    chk("bp_c1_addr", imem_addr, 32'h0);
    cyc(); #3;                                                             // C2
    chk("bp_c2_req", {31'b0, imem_req}, 32'd1);
    chk("bp_c2_addr", imem_addr, 32'h4);
    for (int i = 0; i < 6; i++) begin                                      // C3..C8
      cyc(); #3;
      chk("full_req_low", {31'b0, imem_req}, 32'd0);
      chk("full_valid", {31'b0, out_valid}, 32'd1);
      chk("full_head_pc", out_pc, 32'h0);
    end
    cyc(); out_ready = 1'b1;                                               // C9
    repeat (3) cyc();                                                      // C10..C12
    cyc(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100; // C13
    #3; chk("redir1_head", out_pc, 32'h10);
    cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #3;                    // C14
    chk("redir1_valid_n1", {31'b0, out_valid}, 32'd0);
    chk("redir1_req", {31'b0, imem_req}, 32'd1);
    chk("redir1_addr", imem_addr, 32'h100);
    cyc(); #3; chk("redir1_valid_n2", {31'b0, out_valid}, 32'd0);          // C15
    cyc(); #3;                                                             // C16
    chk("redir1_valid_n3", {31'b0, out_valid}, 32'd1);
    chk("redir1_pc_n3", out_pc, 32'h100);
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h20; #3;            // C17
    chk("redir2_head", out_pc, 32'h104);
    cyc(); redirect_valid = 1'b0; #3;                                      // C18
    chk("redir2_valid_n1", {31'b0, out_valid}, 32'd0);
    chk("redir2_addr", imem_addr, 32'h20);
    cyc();                                                                 // C19
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h40; #3;            // C20
    chk("redir_pop_head", out_pc, 32'h20);
    cyc(); redirect_valid = 1'b0;                                          // C21
    cyc();                                                                 // C22
    cyc(); #3; chk("pre_rst_head", out_pc, 32'h40);                        // C23
    cyc(); rst = 1'b1; out_ready = 1'b0;                                   // C24
    cyc(); rst = 1'b0; out_ready = 1'b1; #3;                               // C25
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    cyc(); #3; chk("post_rst_valid_n2", {31'b0, out_valid}, 32'd0);        // C26
    cyc();                                                                 // C27
    cyc();                                                                 // C28
    cyc();                                                                 // C29
    cyc(); out_ready = 1'b0;                                               // C30
    repeat (3) cyc();

    chk("main_expected_left", 32'(exp_q.size()), 32'd0);
    chk("wrap_expected_left", 32'(exp_w.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
